// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter: write-port encodings,
// queue entry payload, arbitration source enum.
package wb_pkg;

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RW_W   = 2;
  localparam int unsigned CNT_W  = 32;

  localparam logic [RW_W-1:0] REGWRITE_NONE = 2'b00;
  localparam logic [RW_W-1:0] REGWRITE_INT  = 2'b01;
  localparam logic [RW_W-1:0] REGWRITE_FPU  = 2'b10;

  // x0 is hardwired in the integer file; f31 is reserved in the FPU file.
  localparam logic [RD_W-1:0] INT_DISCARD_RD = 5'd0;
  localparam logic [RD_W-1:0] FPU_DISCARD_RD = 5'd31;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic              fpu;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_FPU  = 2'd3
  } wb_src_e;

  function automatic logic wb_is_discard(input wb_entry_t e);
    return e.fpu ? (e.rd == FPU_DISCARD_RD) : (e.rd == INT_DISCARD_RD);
  endfunction

  function automatic logic [CNT_W-1:0] wb_sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer handshakes (ALU, load, FPU) and the register-file write port.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [RD_W-1:0]   alu_rd;
  logic              alu_fpu;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [RD_W-1:0]   mem_rd;
  logic              mem_fpu;
  logic [DATA_W-1:0] mem_data;

  logic              fpu_valid;
  logic              fpu_ready;
  logic [RD_W-1:0]   fpu_rd;
  logic              fpu_fpu;
  logic [DATA_W-1:0] fpu_data;

  logic [RD_W-1:0]   rd_wb;
  logic [DATA_W-1:0] write_data_register_wb;
  logic [RW_W-1:0]   regwrite_wb;

  modport master (
    output alu_valid, alu_rd, alu_fpu, alu_data,
    output mem_valid, mem_rd, mem_fpu, mem_data,
    output fpu_valid, fpu_rd, fpu_fpu, fpu_data,
    input  alu_ready, mem_ready, fpu_ready,
    input  rd_wb, write_data_register_wb, regwrite_wb
  );

  modport slave (
    input  alu_valid, alu_rd, alu_fpu, alu_data,
    input  mem_valid, mem_rd, mem_fpu, mem_data,
    input  fpu_valid, fpu_rd, fpu_fpu, fpu_data,
    output alu_ready, mem_ready, fpu_ready,
    output rd_wb, write_data_register_wb, regwrite_wb
  );

endinterface

// File: rtl/wb_fifo.sv
// Write-back result queue: DEPTH entries (power of two), head is the oldest
// stored entry; pushes into a full queue and pops from an empty one are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU, load and FPU results into the single register-file write port.
// Optional build macro WB_STALL_COUNT_EN adds per-source stall/full counters.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic clk,
  input  logic rst,
  wb_arbiter_if.slave bus
`ifdef WB_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] alu_stall_cnt,
  output logic [CNT_W-1:0] mem_full_cnt,
  output logic [CNT_W-1:0] fpu_full_cnt
`endif
);

  localparam int unsigned AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  wb_entry_t         alu_entry, mem_entry, fpu_entry;
  wb_entry_t         mem_head, fpu_head, win_entry;
  logic              mem_full, mem_empty, fpu_full, fpu_empty;
  logic              mem_push, fpu_push, mem_pop, fpu_pop;
  logic              fpu_force;
  wb_src_e           src;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [RD_W-1:0]   rd_wb_q, rd_wb_d;
  logic [DATA_W-1:0] data_wb_q, data_wb_d;
  logic [RW_W-1:0]   rw_wb_q, rw_wb_d;

  always_comb begin
    alu_entry = '{rd: bus.alu_rd, fpu: bus.alu_fpu, data: bus.alu_data};
    mem_entry = '{rd: bus.mem_rd, fpu: bus.mem_fpu, data: bus.mem_data};
    fpu_entry = '{rd: bus.fpu_rd, fpu: bus.fpu_fpu, data: bus.fpu_data};
  end

  // Readies come from registered queue state only, never from the source's own valid.
  assign fpu_force     = !fpu_empty && (age_q >= AGE_MAX);
  assign bus.mem_ready = !rst && !mem_full;
  assign bus.fpu_ready = !rst && !fpu_full;
  assign bus.alu_ready = !rst && !fpu_force && mem_empty;
  assign mem_push      = bus.mem_valid && bus.mem_ready;
  assign fpu_push      = bus.fpu_valid && bus.fpu_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_data (mem_entry),
    .pop       (mem_pop),
    .full      (mem_full),
    .empty     (mem_empty),
    .head      (mem_head)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fpu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fpu_push),
    .push_data (fpu_entry),
    .pop       (fpu_pop),
    .full      (fpu_full),
    .empty     (fpu_empty),
    .head      (fpu_head)
  );

  // Aged FPU head overrides the fixed MEM > ALU > FPU priority.
  always_comb begin
    src = SRC_NONE;
    if (!rst) begin
      if (fpu_force)          src = SRC_FPU;
      else if (!mem_empty)    src = SRC_MEM;
      else if (bus.alu_valid) src = SRC_ALU;
      else if (!fpu_empty)    src = SRC_FPU;
    end
    case (src)
      SRC_MEM: win_entry = mem_head;
      SRC_ALU: win_entry = alu_entry;
      SRC_FPU: win_entry = fpu_head;
      default: win_entry = '0;
    endcase
    mem_pop = (src == SRC_MEM);
    fpu_pop = (src == SRC_FPU);
  end

  always_comb begin
    rd_wb_d   = '0;
    data_wb_d = '0;
    rw_wb_d   = REGWRITE_NONE;
    age_d     = age_q;
    if ((src != SRC_NONE) && !wb_is_discard(win_entry)) begin
      rd_wb_d   = win_entry.rd;
      data_wb_d = win_entry.data;
      rw_wb_d   = win_entry.fpu ? REGWRITE_FPU : REGWRITE_INT;
    end
    if (fpu_empty || fpu_pop) begin
      age_d = '0;
    end else if (age_q < AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q     <= '0;
      rd_wb_q   <= '0;
      data_wb_q <= '0;
      rw_wb_q   <= REGWRITE_NONE;
    end else begin
      age_q     <= age_d;
      rd_wb_q   <= rd_wb_d;
      data_wb_q <= data_wb_d;
      rw_wb_q   <= rw_wb_d;
    end
  end

  assign bus.rd_wb                  = rd_wb_q;
  assign bus.write_data_register_wb = data_wb_q;
  assign bus.regwrite_wb            = rw_wb_q;

`ifdef WB_STALL_COUNT_EN
  logic [CNT_W-1:0] alu_stall_cnt_q, alu_stall_cnt_d;
  logic [CNT_W-1:0] mem_full_cnt_q, mem_full_cnt_d;
  logic [CNT_W-1:0] fpu_full_cnt_q, fpu_full_cnt_d;

  always_comb begin
    alu_stall_cnt_d = wb_sat_inc(alu_stall_cnt_q, bus.alu_valid && !bus.alu_ready);
    mem_full_cnt_d  = wb_sat_inc(mem_full_cnt_q, bus.mem_valid && !bus.mem_ready);
    fpu_full_cnt_d  = wb_sat_inc(fpu_full_cnt_q, bus.fpu_valid && !bus.fpu_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_stall_cnt_q <= '0;
      mem_full_cnt_q  <= '0;
      fpu_full_cnt_q  <= '0;
    end else begin
      alu_stall_cnt_q <= alu_stall_cnt_d;
      mem_full_cnt_q  <= mem_full_cnt_d;
      fpu_full_cnt_q  <= fpu_full_cnt_d;
    end
  end

  assign alu_stall_cnt = alu_stall_cnt_q;
  assign mem_full_cnt  = mem_full_cnt_q;
  assign fpu_full_cnt  = fpu_full_cnt_q;
`endif

endmodule
